// File: rtl/otter_cu_fsm_pkg.sv
// Shared Otter control types: CU state encoding, RV32I major opcodes and the strobe bundle.
// The CU decoder imports the same opcode constants.
package otter_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } cu_state_t;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] FN_MRET = 3'b000;

   typedef struct packed {
      logic pc_write;
      logic reg_write;
      logic mem_we2;
      logic mem_rden1;
      logic mem_rden2;
      logic rf_reset;
      logic csr_we;
      logic int_taken;
      logic mret_exec;
      logic illegal_instr;
   } cu_ctrl_t;

   // CSRRW / CSRRS / CSRRC; the immediate forms are not supported by this core
   function automatic logic is_csr_func(input logic [2:0] func);
      return (func == 3'b001) || (func == 3'b010) || (func == 3'b011);
   endfunction

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control bus between the CU FSM (master) and the decoder/datapath/CSR file (slave).
interface otter_cu_fsm_if #(
   parameter int INSTRET_W = 32
);
   logic                 csr_mie;
   logic [6:0]           ir_opcode;
   logic [2:0]           ir_func;
   logic                 pc_write;
   logic                 reg_write;
   logic                 mem_we2;
   logic                 mem_rden1;
   logic                 mem_rden2;
   logic                 rf_reset;
   logic                 csr_we;
   logic                 int_taken;
   logic                 mret_exec;
   logic                 illegal_instr;
   logic [INSTRET_W-1:0] instret;

   modport master (
      input  csr_mie, ir_opcode, ir_func,
      output pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rf_reset,
             csr_we, int_taken, mret_exec, illegal_instr, instret
   );

   modport slave (
      output csr_mie, ir_opcode, ir_func,
      input  pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rf_reset,
             csr_we, int_taken, mret_exec, illegal_instr, instret
   );
endinterface

// File: rtl/otter_cu_fsm_intr_sync.sv
// External interrupt synchronizer: SYNC_STAGES-deep flop chain plus rising-edge detect.
module otter_intr_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic intr,
   output logic intr_rise
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_d1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= '0;
         sync_d1 <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], intr};
         sync_d1 <= sync_q[SYNC_STAGES-1];
      end
   end

   // level or pulse on intr yields exactly one rise per low->high transition
   assign intr_rise = sync_q[SYNC_STAGES-1] & ~sync_d1;

endmodule

// File: rtl/otter_cu_fsm.sv
// Otter MCU multi-cycle control FSM: INIT/FETCH/EXEC/WB/INTR sequencing, strobe generation,
// interrupt pending latch and retired-instruction counter.
module otter_cu_fsm
   import otter_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int INSTRET_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  intr,
   otter_cu_fsm_if.master        cu
);
   cu_state_t            state, state_nxt;
   cu_ctrl_t             ctrl;
   logic                 intr_rise;
   logic                 intr_pend;
   logic                 take_intr;
   logic [INSTRET_W-1:0] instret;

   otter_intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_intr_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .intr      (intr),
      .intr_rise (intr_rise)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_INIT;
      else        state <= state_nxt;
   end

   assign take_intr = intr_pend & cu.csr_mie;

   always_comb begin
      state_nxt = ST_INIT;
      case (state)
         ST_INIT:  state_nxt = ST_FETCH;
         ST_FETCH: state_nxt = ST_EXEC;
         ST_EXEC:  if (cu.ir_opcode == OPC_LOAD) state_nxt = ST_WB;
                   else state_nxt = take_intr ? ST_INTR : ST_FETCH;
         ST_WB:    state_nxt = take_intr ? ST_INTR : ST_FETCH;
         ST_INTR:  state_nxt = ST_FETCH;
         default:  state_nxt = ST_INIT;
      endcase
   end

   // While rst_n is low every strobe is suppressed so an abandoned instruction writes nothing.
   always_comb begin
      ctrl = '0;
      if (!rst_n) begin
         ctrl.rf_reset = 1'b1;
      end else begin
         case (state)
            ST_INIT:  ctrl.rf_reset  = 1'b1;
            ST_FETCH: ctrl.mem_rden1 = 1'b1;
            ST_EXEC: begin
               case (cu.ir_opcode)
                  OPC_RTYPE, OPC_ITYPE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                     ctrl.pc_write  = 1'b1;
                     ctrl.reg_write = 1'b1;
                  end
                  OPC_BRANCH: ctrl.pc_write = 1'b1;
                  OPC_STORE: begin
                     ctrl.pc_write = 1'b1;
                     ctrl.mem_we2  = 1'b1;
                  end
                  OPC_LOAD: ctrl.mem_rden2 = 1'b1;
                  OPC_SYSTEM: begin
                     ctrl.pc_write = 1'b1;
                     if (is_csr_func(cu.ir_func)) begin
                        ctrl.csr_we    = 1'b1;
                        ctrl.reg_write = 1'b1;
                     end else if (cu.ir_func == FN_MRET) begin
                        ctrl.mret_exec = 1'b1;
                     end else begin
                        ctrl.illegal_instr = 1'b1;
                     end
                  end
                  default: begin
                     ctrl.pc_write      = 1'b1;
                     ctrl.illegal_instr = 1'b1;
                  end
               endcase
            end
            ST_WB: begin
               ctrl.reg_write = 1'b1;
               ctrl.pc_write  = 1'b1;
            end
            ST_INTR: begin
               ctrl.int_taken = 1'b1;
               ctrl.pc_write  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // a new edge arriving in the INTR cycle must survive the clear
   always_ff @(posedge clk) begin
      if (!rst_n)                 intr_pend <= 1'b0;
      else if (intr_rise)         intr_pend <= 1'b1;
      else if (state == ST_INTR)  intr_pend <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         instret <= '0;
      else if (((state == ST_EXEC) || (state == ST_WB)) && ctrl.pc_write)
         instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
   end

   assign cu.pc_write      = ctrl.pc_write;
   assign cu.reg_write     = ctrl.reg_write;
   assign cu.mem_we2       = ctrl.mem_we2;
   assign cu.mem_rden1     = ctrl.mem_rden1;
   assign cu.mem_rden2     = ctrl.mem_rden2;
   assign cu.rf_reset      = ctrl.rf_reset;
   assign cu.csr_we        = ctrl.csr_we;
   assign cu.int_taken     = ctrl.int_taken;
   assign cu.mret_exec     = ctrl.mret_exec;
   assign cu.illegal_instr = ctrl.illegal_instr;
   assign cu.instret       = instret;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed self-checking bench for otter_cu_fsm (INSTRET_W=4 so the counter wrap is reachable).
module tb_otter_cu_fsm;
   import otter_pkg::*;

   // strobe vector order: pc,reg,we2,rden1,rden2,rf_reset,csr_we,int_taken,mret,illegal
   localparam logic [9:0] O_PC   = 10'b10_0000_0000;
   localparam logic [9:0] O_REG  = 10'b01_0000_0000;
   localparam logic [9:0] O_WE2  = 10'b00_1000_0000;
   localparam logic [9:0] O_RD1  = 10'b00_0100_0000;
   localparam logic [9:0] O_RD2  = 10'b00_0010_0000;
   localparam logic [9:0] O_RF   = 10'b00_0001_0000;
   localparam logic [9:0] O_CSR  = 10'b00_0000_1000;
   localparam logic [9:0] O_INT  = 10'b00_0000_0100;
   localparam logic [9:0] O_MRET = 10'b00_0000_0010;
   localparam logic [9:0] O_ILL  = 10'b00_0000_0001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       intr;
   logic [9:0] outs;
   logic [3:0] exp_cnt;
   int         n_checks = 0;
   int         n_fail   = 0;

   otter_cu_fsm_if #(.INSTRET_W(4)) cu ();

   otter_cu_fsm #(.SYNC_STAGES(2), .INSTRET_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .intr  (intr),
      .cu    (cu)
   );

   always #5 clk = ~clk;

   assign outs = {cu.pc_write, cu.reg_write, cu.mem_we2, cu.mem_rden1, cu.mem_rden2,
                  cu.rf_reset, cu.csr_we, cu.int_taken, cu.mret_exec, cu.illegal_instr};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present an instruction during FETCH and advance into its EXEC cycle
   task automatic fetch_exec(input logic [6:0] op, input logic [2:0] fn);
      cu.ir_opcode = op;
      cu.ir_func   = fn;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if (outs !== O_RF) begin n_fail++; $display("FAIL reset_hold outs=%b exp=%b", outs, O_RF); end
      tick();
      n_checks++;
      if (cu.instret !== 4'd0) begin n_fail++; $display("FAIL reset_instret got=%0d exp=0", cu.instret); end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_RF) begin n_fail++; $display("FAIL reset_init outs=%b exp=%b", outs, O_RF); end
      tick();
      n_checks++;
      if (outs !== O_RD1) begin n_fail++; $display("FAIL reset_fetch outs=%b exp=%b", outs, O_RD1); end
      exp_cnt = 4'd0;
   endtask

   task automatic test_alu_load();
      fetch_exec(OPC_RTYPE, 3'b000);
      n_checks++;
      if (outs !== (O_PC | O_REG)) begin n_fail++; $display("FAIL add_exec outs=%b exp=%b", outs, O_PC | O_REG); end
      tick();
      exp_cnt++;
      n_checks++;
      if (cu.instret !== exp_cnt) begin n_fail++; $display("FAIL add_instret got=%0d exp=%0d", cu.instret, exp_cnt); end
      fetch_exec(OPC_LOAD, 3'b010);
      n_checks++;
      if (outs !== O_RD2) begin n_fail++; $display("FAIL lw_exec outs=%b exp=%b", outs, O_RD2); end
      tick();
      n_checks++;
      if (outs !== (O_PC | O_REG)) begin n_fail++; $display("FAIL lw_wb outs=%b exp=%b", outs, O_PC | O_REG); end
      n_checks++;
      if (cu.instret !== exp_cnt) begin n_fail++; $display("FAIL lw_wb_instret got=%0d exp=%0d", cu.instret, exp_cnt); end
      tick();
      exp_cnt++;
      n_checks++;
      if (outs !== O_RD1) begin n_fail++; $display("FAIL lw_next outs=%b exp=%b", outs, O_RD1); end
      n_checks++;
      if (cu.instret !== exp_cnt) begin n_fail++; $display("FAIL lw_instret got=%0d exp=%0d", cu.instret, exp_cnt); end
   endtask

   task automatic test_store_sys();
      logic [6:0] ops [6] = '{OPC_STORE, OPC_SYSTEM, OPC_SYSTEM, OPC_SYSTEM, 7'b0000000, OPC_SYSTEM};
      logic [2:0] fns [6] = '{3'b010, 3'b001, 3'b010, 3'b000, 3'b000, 3'b100};
      logic [9:0] exps [6] = '{O_PC | O_WE2, O_CSR | O_REG | O_PC, O_CSR | O_REG | O_PC,
                               O_MRET | O_PC, O_PC | O_ILL, O_PC | O_ILL};
      for (int i = 0; i < 6; i++) begin
         fetch_exec(ops[i], fns[i]);
         n_checks++;
         if (outs !== exps[i]) begin
            n_fail++;
            $display("FAIL store_sys_exec[%0d] outs=%b exp=%b", i, outs, exps[i]);
         end
         tick();
         exp_cnt++;
      end
      n_checks++;
      if (cu.instret !== exp_cnt) begin n_fail++; $display("FAIL store_sys_instret got=%0d exp=%0d", cu.instret, exp_cnt); end
   endtask

   task automatic test_intr();
      cu.csr_mie = 1'b1;
      intr = 1'b1;
      fetch_exec(OPC_RTYPE, 3'b000);
      intr = 1'b0;
      tick();
      exp_cnt++;
      n_checks++;
      if (outs !== O_RD1) begin n_fail++; $display("FAIL intr_early outs=%b exp=%b", outs, O_RD1); end
      fetch_exec(OPC_RTYPE, 3'b000);
      tick();
      exp_cnt++;
      n_checks++;
      if (outs !== (O_INT | O_PC)) begin n_fail++; $display("FAIL intr_taken outs=%b exp=%b", outs, O_INT | O_PC); end
      tick();
      n_checks++;
      if (outs !== O_RD1) begin n_fail++; $display("FAIL intr_refetch outs=%b exp=%b", outs, O_RD1); end
      n_checks++;
      if (cu.instret !== exp_cnt) begin n_fail++; $display("FAIL intr_instret got=%0d exp=%0d", cu.instret, exp_cnt); end
      // pulse timed so the pend bit is already set during the LW EXEC
      intr = 1'b1;
      fetch_exec(OPC_RTYPE, 3'b000);
      intr = 1'b0;
      tick();
      exp_cnt++;
      fetch_exec(OPC_LOAD, 3'b010);
      n_checks++;
      if (outs !== O_RD2) begin n_fail++; $display("FAIL intr_lw_exec outs=%b exp=%b", outs, O_RD2); end
      tick();
      n_checks++;
      if (outs !== (O_PC | O_REG)) begin n_fail++; $display("FAIL intr_lw_wb outs=%b exp=%b", outs, O_PC | O_REG); end
      tick();
      exp_cnt++;
      n_checks++;
      if (outs !== (O_INT | O_PC)) begin n_fail++; $display("FAIL intr_after_wb outs=%b exp=%b", outs, O_INT | O_PC); end
      tick();
      n_checks++;
      if (outs !== O_RD1) begin n_fail++; $display("FAIL intr_lw_refetch outs=%b exp=%b", outs, O_RD1); end
   endtask

   task automatic test_mie_mask();
      cu.csr_mie = 1'b0;
      for (int i = 0; i < 10; i++) begin
         intr = (i == 0);
         fetch_exec(OPC_ITYPE, 3'b000);
         intr = 1'b0;
         tick();
         exp_cnt++;
         n_checks++;
         if (outs !== O_RD1) begin n_fail++; $display("FAIL mask_boundary[%0d] outs=%b exp=%b", i, outs, O_RD1); end
      end
      // new edge lands in the INTR cycle and must re-arm the pend bit
      cu.csr_mie = 1'b1;
      intr = 1'b1;
      fetch_exec(OPC_RTYPE, 3'b000);
      intr = 1'b0;
      tick();
      exp_cnt++;
      n_checks++;
      if (outs !== (O_INT | O_PC)) begin n_fail++; $display("FAIL unmask_intr outs=%b exp=%b", outs, O_INT | O_PC); end
      tick();
      fetch_exec(OPC_RTYPE, 3'b000);
      tick();
      exp_cnt++;
      n_checks++;
      if (outs !== (O_INT | O_PC)) begin n_fail++; $display("FAIL second_intr outs=%b exp=%b", outs, O_INT | O_PC); end
      tick();
      fetch_exec(OPC_RTYPE, 3'b000);
      tick();
      exp_cnt++;
      n_checks++;
      if (outs !== O_RD1) begin n_fail++; $display("FAIL no_third_intr outs=%b exp=%b", outs, O_RD1); end
      n_checks++;
      if (cu.instret !== exp_cnt) begin n_fail++; $display("FAIL mask_instret got=%0d exp=%0d", cu.instret, exp_cnt); end
   endtask

   task automatic test_reset_mid_load();
      fetch_exec(OPC_LOAD, 3'b010);
      tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (outs !== O_RF) begin n_fail++; $display("FAIL rst_in_wb outs=%b exp=%b", outs, O_RF); end
      tick();
      n_checks++;
      if (cu.instret !== 4'd0) begin n_fail++; $display("FAIL rst_wb_instret got=%0d exp=0", cu.instret); end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (outs !== O_RF) begin n_fail++; $display("FAIL rst_wb_init outs=%b exp=%b", outs, O_RF); end
      tick();
      n_checks++;
      if (outs !== O_RD1) begin n_fail++; $display("FAIL rst_wb_fetch outs=%b exp=%b", outs, O_RD1); end
      exp_cnt = 4'd0;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 16; i++) begin
         fetch_exec(OPC_RTYPE, 3'b000);
         tick();
         exp_cnt++;
         n_checks++;
         if (cu.instret !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrap_instret[%0d] got=%0d exp=%0d", i, cu.instret, exp_cnt);
         end
      end
      n_checks++;
      if (cu.instret !== 4'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", cu.instret); end
   endtask

   initial begin
      rst_n        = 1'b0;
      intr         = 1'b0;
      cu.csr_mie   = 1'b0;
      cu.ir_opcode = 7'b0;
      cu.ir_func   = 3'b0;
      exp_cnt      = 4'd0;
      test_reset();
      test_alu_load();
      test_store_sys();
      test_intr();
      test_mie_mask();
      test_reset_mid_load();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
